// File: rtl/vdp_timing_pkg.sv
// Shared video timing definitions: timing record, the four supported modes,
// and the mode-controller state encoding.
package vdp_timing_pkg;

    localparam int NUM_RES = 4;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    localparam timing_t TIMING_0 = '{h_total: 12'd800, h_sync: 12'd96, h_bporch: 12'd48,
        h_res: 12'd640, v_total: 12'd525, v_sync: 12'd2, v_bporch: 12'd33, v_res: 12'd480,
        hs_pol: 1'b0, vs_pol: 1'b0};
    localparam timing_t TIMING_1 = '{h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88,
        h_res: 12'd800, v_total: 12'd628, v_sync: 12'd4, v_bporch: 12'd23, v_res: 12'd600,
        hs_pol: 1'b1, vs_pol: 1'b1};
    localparam timing_t TIMING_2 = '{h_total: 12'd1650, h_sync: 12'd40, h_bporch: 12'd220,
        h_res: 12'd1280, v_total: 12'd750, v_sync: 12'd5, v_bporch: 12'd20, v_res: 12'd720,
        hs_pol: 1'b1, vs_pol: 1'b1};
    localparam timing_t TIMING_3 = '{h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160,
        h_res: 12'd1024, v_total: 12'd806, v_sync: 12'd6, v_bporch: 12'd29, v_res: 12'd768,
        hs_pol: 1'b0, vs_pol: 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAT_WAIT,
        ST_WAIT_VS,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    function automatic timing_t timing_lookup(input logic [1:0] idx);
        case (idx)
            2'd0:    return TIMING_0;
            2'd1:    return TIMING_1;
            2'd2:    return TIMING_2;
            default: return TIMING_3;
        endcase
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Vertical-sync rise detector: normalises polarity so "active" means in-sync,
// then registers the 0->1 transition.
module vs_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic pol,
    output logic vs_rise
);

    logic vs_act;
    logic vs_act_q;

    assign vs_act = ~(vs ^ pol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q <= 1'b0;
            vs_rise  <= 1'b0;
        end else begin
            vs_act_q <= vs_act;
            vs_rise  <= vs_act & ~vs_act_q;
        end
    end

endmodule

// File: rtl/video_mode_ctrl.sv
// Run-time video mode controller: applies resolution changes under generator
// reset at vsync, pattern-only changes at vsync. Optional AUTO_CYCLE_EN steps the pattern.
module video_mode_ctrl
    import vdp_timing_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int WAIT_TIMEOUT = 2000000,
    parameter int AUTO_FRAMES  = 120
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic [2:0]  I_req_res,
    input  logic [2:0]  I_req_pattern,
    input  logic        I_vs,
    output logic        O_gen_rst_n,
    output logic [11:0] O_h_total,
    output logic [11:0] O_h_sync,
    output logic [11:0] O_h_bporch,
    output logic [11:0] O_h_res,
    output logic [11:0] O_v_total,
    output logic [11:0] O_v_sync,
    output logic [11:0] O_v_bporch,
    output logic [11:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic [2:0]  O_mode,
    output logic        O_busy,
    output logic        O_err
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [20:0]   TO_LAST   = 21'(WAIT_TIMEOUT - 1);

    if (HOLD_CYCLES < 2 || AUTO_FRAMES < 1) begin : g_param_chk
        $error("video_mode_ctrl: HOLD_CYCLES must be >= 2 and AUTO_FRAMES >= 1");
    end

    state_t          state;
    timing_t         timing_q;
    logic [HW-1:0]   hold_cnt;
    logic [20:0]     to_cnt;
    logic [1:0]      res_q;
    logic [1:0]      cur_res;
    logic [2:0]      pat_q;
    logic            vs_rise;
    logic            to_done;

`ifdef AUTO_CYCLE_EN
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);
    logic [FW-1:0] frame_cnt;
`endif

    vs_edge_det u_vs_edge_det (
        .clk     (I_pxl_clk),
        .rst_n   (I_rst_n),
        .vs      (I_vs),
        .pol     (timing_q.vs_pol),
        .vs_rise (vs_rise)
    );

    assign to_done    = (to_cnt == TO_LAST);
    assign O_h_total  = timing_q.h_total;
    assign O_h_sync   = timing_q.h_sync;
    assign O_h_bporch = timing_q.h_bporch;
    assign O_h_res    = timing_q.h_res;
    assign O_v_total  = timing_q.v_total;
    assign O_v_sync   = timing_q.v_sync;
    assign O_v_bporch = timing_q.v_bporch;
    assign O_v_res    = timing_q.v_res;
    assign O_hs_pol   = timing_q.hs_pol;
    assign O_vs_pol   = timing_q.vs_pol;

    // Reset lands in HOLD so the generator gets a full boot hold on every reset.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= ST_HOLD;
            timing_q    <= TIMING_0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            res_q       <= '0;
            cur_res     <= '0;
            pat_q       <= '0;
            O_mode      <= '0;
            O_gen_rst_n <= 1'b0;
            O_req_ready <= 1'b0;
            O_busy      <= 1'b1;
            O_err       <= 1'b0;
`ifdef AUTO_CYCLE_EN
            frame_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_req_valid && O_req_ready) begin
                        if (I_req_res >= 3'(NUM_RES)) begin
                            O_err <= 1'b1;
                        end else begin
                            res_q       <= I_req_res[1:0];
                            pat_q       <= I_req_pattern;
                            to_cnt      <= '0;
                            O_req_ready <= 1'b0;
                            O_busy      <= 1'b1;
                            state       <= (I_req_res[1:0] == cur_res) ? ST_PAT_WAIT : ST_WAIT_VS;
`ifdef AUTO_CYCLE_EN
                            frame_cnt   <= '0;
`endif
                        end
                    end
`ifdef AUTO_CYCLE_EN
                    else if (vs_rise) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            O_mode    <= O_mode + 3'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_PAT_WAIT: begin
                    if (vs_rise || to_done) begin
                        O_mode      <= pat_q;
                        O_req_ready <= 1'b1;
                        O_busy      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 21'd1;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_rise || to_done) begin
                        O_gen_rst_n <= 1'b0;
                        hold_cnt    <= '0;
                        state       <= ST_HOLD;
                    end else begin
                        to_cnt <= to_cnt + 21'd1;
                    end
                end
                ST_HOLD: begin
                    // New timing is applied only while the generator is held in reset.
                    if (hold_cnt == '0) begin
                        timing_q <= timing_lookup(res_q);
                        cur_res  <= res_q;
                        O_mode   <= pat_q;
                    end
                    if (hold_cnt == HOLD_LAST) begin
                        O_gen_rst_n <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    O_req_ready <= 1'b1;
                    O_busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: boot hold, resolution change, pattern-only
// change, invalid index, wait timeout with mid-hold reset, and optional auto cycling.
module tb_video_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_res;
    logic [2:0]  req_pattern;
    logic        vs;
    logic        gen_rst_n;
    logic [11:0] h_total, h_sync, h_bporch, h_res;
    logic [11:0] v_total, v_sync, v_bporch, v_res;
    logic        hs_pol, vs_pol;
    logic [2:0]  mode;
    logic        busy;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;
    int n;

    always #5 clk = ~clk;

    video_mode_ctrl #(
        .HOLD_CYCLES  (16),
        .WAIT_TIMEOUT (100),
        .AUTO_FRAMES  (2)
    ) dut (
        .I_pxl_clk     (clk),
        .I_rst_n       (rst_n),
        .I_req_valid   (req_valid),
        .O_req_ready   (req_ready),
        .I_req_res     (req_res),
        .I_req_pattern (req_pattern),
        .I_vs          (vs),
        .O_gen_rst_n   (gen_rst_n),
        .O_h_total     (h_total),
        .O_h_sync      (h_sync),
        .O_h_bporch    (h_bporch),
        .O_h_res       (h_res),
        .O_v_total     (v_total),
        .O_v_sync      (v_sync),
        .O_v_bporch    (v_bporch),
        .O_v_res       (v_res),
        .O_hs_pol      (hs_pol),
        .O_vs_pol      (vs_pol),
        .O_mode        (mode),
        .O_busy        (busy),
        .O_err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Counts consecutive low samples of the generator reset, one per clock.
    task automatic measure_hold(output int cnt);
        cnt = 0;
        while (gen_rst_n === 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_timing(input string tag, input int ht, input int hsy, input int hbp,
                                input int hr, input int vt, input int vsy, input int vbp,
                                input int vr, input int pol);
        check({tag, "_h_total"}, 32'(h_total), ht);
        check({tag, "_h_sync"}, 32'(h_sync), hsy);
        check({tag, "_h_bporch"}, 32'(h_bporch), hbp);
        check({tag, "_h_res"}, 32'(h_res), hr);
        check({tag, "_v_total"}, 32'(v_total), vt);
        check({tag, "_v_sync"}, 32'(v_sync), vsy);
        check({tag, "_v_bporch"}, 32'(v_bporch), vbp);
        check({tag, "_v_res"}, 32'(v_res), vr);
        check({tag, "_hs_pol"}, 32'(hs_pol), pol);
        check({tag, "_vs_pol"}, 32'(vs_pol), pol);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_res = 3'd0; req_pattern = 3'd0; vs = 1'b1;
        cyc(3);
        check("rst_gen_rst_n", 32'(gen_rst_n), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_err", 32'(err), 0);
        check("rst_mode", 32'(mode), 0);
        check_timing("rst", 800, 96, 48, 640, 525, 2, 33, 480, 0);

        // Boot hold
        rst_n = 1'b1;
        measure_hold(n);
        check("boot_hold_len", n, 16);
        check("boot_busy_release", 32'(busy), 1);
        cyc(1);
        check("boot_busy_idle", 32'(busy), 0);
        check("boot_ready_idle", 32'(req_ready), 1);
        check_timing("boot", 800, 96, 48, 640, 525, 2, 33, 480, 0);

        // Pattern-only change at res 0
        req_valid = 1'b1; req_res = 3'd0; req_pattern = 3'd3;
        cyc(1);
        check("pat_ready_drop", 32'(req_ready), 0);
        check("pat_busy", 32'(busy), 1);
        req_valid = 1'b0;
        cyc(2);
        check("pat_mode_wait", 32'(mode), 0);
        vs = 1'b0;
        cyc(1);
        check("pat_mode_at_rise", 32'(mode), 0);
        check("pat_gen_rst_rise", 32'(gen_rst_n), 1);
        cyc(1);
        check("pat_mode_applied", 32'(mode), 3);
        check("pat_gen_rst_after", 32'(gen_rst_n), 1);
        check("pat_ready_back", 32'(req_ready), 1);
        check("pat_h_total", 32'(h_total), 800);
        vs = 1'b1;
        cyc(2);

        // Resolution change to index 2; request held while busy is not re-accepted
        req_valid = 1'b1; req_res = 3'd2; req_pattern = 3'd1;
        cyc(1);
        check("res_ready_drop", 32'(req_ready), 0);
        check("res_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("res_busy_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        check("res_no_change_h", 32'(h_total), 800);
        check("res_no_gen_rst", 32'(gen_rst_n), 1);
        vs = 1'b0;
        cyc(2);
        check("res_gen_rst_low", 32'(gen_rst_n), 0);
        check("res_h_before_load", 32'(h_total), 800);
        measure_hold(n);
        check("res_hold_len", n, 16);
        check_timing("res2", 1650, 40, 220, 1280, 750, 5, 20, 720, 1);
        check("res_mode", 32'(mode), 1);
        cyc(1);
        check("res_ready_back", 32'(req_ready), 1);
        check("res_busy_idle", 32'(busy), 0);

        // Invalid index, then a valid request to index 1
        req_valid = 1'b1; req_res = 3'd5; req_pattern = 3'd7;
        cyc(1);
        check("inv_err", 32'(err), 1);
        check("inv_ready", 32'(req_ready), 1);
        check("inv_busy", 32'(busy), 0);
        check("inv_h_total", 32'(h_total), 1650);
        check("inv_mode", 32'(mode), 1);
        req_valid = 1'b0;
        cyc(1);
        req_valid = 1'b1; req_res = 3'd1; req_pattern = 3'd2;
        cyc(1);
        check("inv_next_ready", 32'(req_ready), 0);
        check("inv_next_busy", 32'(busy), 1);
        req_valid = 1'b0;
        cyc(1);
        vs = 1'b1;
        cyc(2);
        check("res1_gen_rst_low", 32'(gen_rst_n), 0);
        vs = 1'b0;
        measure_hold(n);
        check("res1_hold_len", n, 16);
        check_timing("res1", 1056, 128, 88, 800, 628, 4, 23, 600, 1);
        check("res1_mode", 32'(mode), 2);
        check("res1_err_sticky", 32'(err), 1);
        cyc(1);

        // Wait timeout with vsync held inactive, then reset in the middle of HOLD
        req_valid = 1'b1; req_res = 3'd3; req_pattern = 3'd4;
        cyc(1);
        req_valid = 1'b0;
        n = 0;
        while (gen_rst_n === 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        check("to_latency", n, 100);
        cyc(5);
        check("to_h_loaded", 32'(h_total), 1344);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_gen", 32'(gen_rst_n), 0);
        check("mid_rst_h_total", 32'(h_total), 800);
        check("mid_rst_mode", 32'(mode), 0);
        check("mid_rst_busy", 32'(busy), 1);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_err", 32'(err), 0);
        cyc(1);
        rst_n = 1'b1;
        measure_hold(n);
        check("reboot_hold_len", n, 16);
        cyc(1);
        check("reboot_busy", 32'(busy), 0);
        check_timing("reboot", 800, 96, 48, 640, 525, 2, 33, 480, 0);

`ifdef AUTO_CYCLE_EN
        begin
            int exp_mode [5] = '{0, 1, 1, 2, 2};
            vs = 1'b1;
            cyc(2);
            for (int k = 0; k < 5; k++) begin
                vs = 1'b0;
                cyc(2);
                vs = 1'b1;
                cyc(2);
                check("auto_mode", 32'(mode), exp_mode[k]);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
